crossbar_ctrl_3x3: RTL

Arbiter/scheduler for the 3-input, 3-output crossbar datapath.
- Takes val/rdy requests from three input ports, each carrying a 2-bit destination.
- Round-robin arbitrates per output, with multi-flit packet locking.
- Drives the crossbar mux selects sel0..sel2 and the val/rdy handshakes on both sides.
- Sits between the input queues and the output channels of the 3-port router/network-interface datapath.

---
 rtl/crossbar_ctrl_3x3.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/crossbar_ctrl_3x3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crossbar_ctrl_3x3 : round-robin 3x3 crossbar scheduler with packet lock.  |
// | Optional per-output transfer counters: CROSSBAR_CTRL_STATS_EN.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module crossbar_ctrl_3x3 #(
   parameter int NUM_PORTS = 3,
   parameter int CNT_WIDTH = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in0_val,
   input  logic       in1_val,
   input  logic       in2_val,
   input  logic [1:0] in0_dest,
   input  logic [1:0] in1_dest,
   input  logic [1:0] in2_dest,
   input  logic       in0_last,
   input  logic       in1_last,
   input  logic       in2_last,
   output logic       in0_rdy,
   output logic       in1_rdy,
   output logic       in2_rdy,
   output logic       out0_val,
   output logic       out1_val,
   output logic       out2_val,
   input  logic       out0_rdy,
   input  logic       out1_rdy,
   input  logic       out2_rdy,
   output logic [1:0] sel0,
   output logic [1:0] sel1,
   output logic [1:0] sel2
`ifdef CROSSBAR_CTRL_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] out0_xfer_cnt,
   output logic [CNT_WIDTH-1:0] out1_xfer_cnt,
   output logic [CNT_WIDTH-1:0] out2_xfer_cnt
`endif
);

   generate
      if (NUM_PORTS != 3) begin : g_bad_num_ports
         $error("crossbar_ctrl_3x3: NUM_PORTS must be 3");
      end
   endgenerate

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   logic [2:0] val_w;
   logic [2:0] last_w;
   logic [2:0] ordy_w;
   logic [1:0] dest_w [3];

   assign val_w     = {in2_val, in1_val, in0_val};
   assign last_w    = {in2_last, in1_last, in0_last};
   assign ordy_w    = {out2_rdy, out1_rdy, out0_rdy};
   assign dest_w[0] = in0_dest;
   assign dest_w[1] = in1_dest;
   assign dest_w[2] = in2_dest;

   logic [1:0] ptr_q [3];
   logic [1:0] ptr_d [3];
   logic [1:0] lock_src_q [3];
   logic [1:0] lock_src_d [3];
   logic [2:0] lock_q;
   logic [2:0] lock_d;

   // req[k][i]: input i wants output k; dest 3 never matches any output
   logic [2:0] req [3];
   logic [2:0] gnt_vld;
   logic [1:0] gnt_src [3];
   logic [2:0] xfer;
   logic [2:0] in_rdy;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) begin
            req[k][i] = val_w[i] && (dest_w[i] == 2'(k));
         end
      end
   end

   always_comb begin
      logic [1:0] idx;
      idx = 2'd0;
      for (int k = 0; k < 3; k++) begin
         gnt_vld[k] = 1'b0;
         gnt_src[k] = 2'd0;
         if (lock_q[k]) begin
            if (req[k][lock_src_q[k]]) begin
               gnt_vld[k] = 1'b1;
               gnt_src[k] = lock_src_q[k];
            end
         end else begin
            // Scan from the farthest offset down so the one nearest ptr wins.
            for (int o = 2; o >= 0; o--) begin
               idx = wrap3({1'b0, ptr_q[k]} + 3'(o));
               if (req[k][idx]) begin
                  gnt_vld[k] = 1'b1;
                  gnt_src[k] = idx;
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         in_rdy[i] = 1'b0;
         if (dest_w[i] != 2'd3) begin
            in_rdy[i] = gnt_vld[dest_w[i]] && (gnt_src[dest_w[i]] == 2'(i))
                        && ordy_w[dest_w[i]];
         end
      end
   end

   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      lock_src_d = lock_src_q;
      xfer       = 3'b000;
      for (int k = 0; k < 3; k++) begin
         xfer[k] = gnt_vld[k] && ordy_w[k];
         if (xfer[k]) begin
            if (last_w[gnt_src[k]]) begin
               lock_d[k] = 1'b0;
               ptr_d[k]  = wrap3({1'b0, gnt_src[k]} + 3'd1);
            end else begin
               lock_d[k]     = 1'b1;
               lock_src_d[k] = gnt_src[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 3; k++) begin
            ptr_q[k]      <= 2'd0;
            lock_src_q[k] <= 2'd0;
         end
         lock_q <= 3'b000;
      end else begin
         ptr_q      <= ptr_d;
         lock_src_q <= lock_src_d;
         lock_q     <= lock_d;
      end
   end

   assign in0_rdy  = in_rdy[0];
   assign in1_rdy  = in_rdy[1];
   assign in2_rdy  = in_rdy[2];
   assign out0_val = gnt_vld[0];
   assign out1_val = gnt_vld[1];
   assign out2_val = gnt_vld[2];
   assign sel0     = gnt_src[0];
   assign sel1     = gnt_src[1];
   assign sel2     = gnt_src[2];

`ifdef CROSSBAR_CTRL_STATS_EN
   logic [CNT_WIDTH-1:0] cnt_q [3];
   logic [CNT_WIDTH-1:0] cnt_d [3];

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         cnt_d[k] = cnt_q[k] + CNT_WIDTH'(xfer[k]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 3; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out0_xfer_cnt = cnt_q[0];
   assign out1_xfer_cnt = cnt_q[1];
   assign out2_xfer_cnt = cnt_q[2];
`endif

endmodule
`default_nettype wire
